// File: rtl/tdm_demux.sv
// Receiver side of a round-robin TDM word stream: collects one word per lane
// and presents each complete frame on a parallel bus with valid/ready.
module tdm_demux #(
   parameter int N_LANES = 4,
   parameter int WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic                     in_sof,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_LANES*WIDTH-1:0] out_data,
   output logic                     sync_err
);

   localparam int              CW   = $clog2(N_LANES);
   localparam int              FW   = N_LANES * WIDTH;
   localparam logic [CW-1:0]   LAST = CW'(N_LANES - 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [FW-1:0]   coll_buf;
   logic [FW-1:0]   frame;
   logic            last_slot;
   logic            take;

   // Only a completing beat needs the output register, so only it can stall.
   assign last_slot = (state == COLLECT) && (cnt == LAST);
   assign in_ready  = !(last_slot && out_valid && !out_ready);
   assign take      = in_valid && in_ready;

   // Completed frame: collected slots with the final word merged in place.
   always_comb begin
      frame = coll_buf;
      frame[cnt*WIDTH +: WIDTH] = in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         coll_buf  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         sync_err  <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so a later assignment in this block
         // overrides an earlier default (out_valid clear vs. new frame).
         sync_err <= 1'b0;
         if (out_valid && out_ready)
            out_valid <= 1'b0;

         if (take) begin
            if (in_sof) begin
               // A SOF while collecting (including on the last slot) restarts.
               coll_buf[WIDTH-1:0] <= in_data;
               cnt                 <= CW'(1);
               state               <= COLLECT;
               if (state == COLLECT)
                  sync_err <= 1'b1;
            end else if (state == IDLE) begin
               sync_err <= 1'b1;
            end else if (cnt == LAST) begin
               out_data  <= frame;
               out_valid <= 1'b1;
               cnt       <= '0;
               state     <= IDLE;
            end else begin
               coll_buf[cnt*WIDTH +: WIDTH] <= in_data;
               cnt                          <= cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_LANES=4, WIDTH=8): frame assembly, gaps,
// backpressure, early SOF, missing SOF and asynchronous reset.
module tb_tdm_demux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        sync_err;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          err_count = 0;
   logic [31:0] frames[$];

   tdm_demux #(.N_LANES(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sync_err  (sync_err)
   );

   always #5 clk = ~clk;

   // Mid-cycle monitor: transfers and error pulses seen at the next rising edge.
   always @(negedge clk) begin
      if (out_valid && out_ready)
         frames.push_back(out_data);
      if (sync_err)
         err_count++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents one beat and returns 1 ns after the edge that accepted it.
   task automatic send(input logic sof, input logic [7:0] d);
      int guard = 0;
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = d;
      while (!in_ready && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 50)
         check("send_timeout", 64'(guard), 64'(0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic check_frames(input string tag, input logic [31:0] exp);
      check({tag, "_count"}, 64'(frames.size()), 64'(1));
      if (frames.size() > 0)
         check({tag, "_data"}, 64'(frames[0]), 64'(exp));
      frames.delete();
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data",  64'(out_data),  64'(0));
      check("rst_sync_err",  64'(sync_err),  64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // 1: back-to-back beats
      send(1'b1, 8'h11);
      send(1'b0, 8'h22);
      send(1'b0, 8'h33);
      check("t1_no_valid_early", 64'(out_valid), 64'(0));
      send(1'b0, 8'h44);
      check("t1_out_valid", 64'(out_valid), 64'(1));
      check("t1_out_data",  64'(out_data),  64'h4433_2211);
      idle(2);
      check_frames("t1_frame", 32'h4433_2211);
      check("t1_no_err", 64'(err_count), 64'(0));

      // 2: two idle cycles between beats
      send(1'b1, 8'h11); idle(2);
      send(1'b0, 8'h22); idle(2);
      send(1'b0, 8'h33); idle(2);
      check("t2_no_valid_early", 64'(out_valid), 64'(0));
      send(1'b0, 8'h44);
      check("t2_out_valid", 64'(out_valid), 64'(1));
      check("t2_out_data",  64'(out_data),  64'h4433_2211);
      idle(2);
      check_frames("t2_frame", 32'h4433_2211);

      // 3: backpressure with frame A pending
      out_ready = 1'b0;
      send(1'b1, 8'hC1);
      send(1'b0, 8'hC2);
      send(1'b0, 8'hC3);
      send(1'b0, 8'hC4);
      check("t3_a_valid", 64'(out_valid), 64'(1));
      send(1'b1, 8'hA1);
      send(1'b0, 8'hA2);
      send(1'b0, 8'hA3);
      in_valid = 1'b1;
      in_data  = 8'hA4;
      #1;
      check("t3_in_ready_low", 64'(in_ready), 64'(0));
      idle(1);
      check("t3_a_held",       64'(out_data), 64'hC4C3_C2C1);
      check("t3_still_low",    64'(in_ready), 64'(0));
      out_ready = 1'b1;
      #1;
      check("t3_in_ready_high", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("t3_b_valid", 64'(out_valid), 64'(1));
      check("t3_b_data",  64'(out_data),  64'hA4A3_A2A1);
      idle(2);
      check("t3_two_frames", 64'(frames.size()), 64'(2));
      if (frames.size() == 2) begin
         check("t3_first_a",  64'(frames[0]), 64'hC4C3_C2C1);
         check("t3_second_b", 64'(frames[1]), 64'hA4A3_A2A1);
      end
      frames.delete();

      // 4: early SOF drops the partial frame
      err_count = 0;
      send(1'b1, 8'h01);
      send(1'b0, 8'h02);
      send(1'b1, 8'h10);
      check("t4_err_pulse", 64'(sync_err), 64'(1));
      send(1'b0, 8'h20);
      check("t4_err_cleared", 64'(sync_err), 64'(0));
      send(1'b0, 8'h30);
      send(1'b0, 8'h40);
      idle(2);
      check("t4_err_count", 64'(err_count), 64'(1));
      check_frames("t4_frame", 32'h4030_2010);

      // 5: words without SOF in IDLE are discarded
      err_count = 0;
      send(1'b0, 8'h55);
      send(1'b0, 8'h66);
      send(1'b1, 8'h78);
      send(1'b0, 8'h56);
      send(1'b0, 8'h34);
      send(1'b0, 8'h12);
      idle(2);
      check("t5_err_count", 64'(err_count), 64'(2));
      check_frames("t5_frame", 32'h1234_5678);

      // SOF on the last slot restarts the frame
      err_count = 0;
      send(1'b1, 8'h0A);
      send(1'b0, 8'h0B);
      send(1'b0, 8'h0C);
      send(1'b1, 8'h04);
      check("t7_no_valid", 64'(out_valid), 64'(0));
      send(1'b0, 8'h05);
      send(1'b0, 8'h06);
      send(1'b0, 8'h07);
      idle(2);
      check("t7_err_count", 64'(err_count), 64'(1));
      check_frames("t7_frame", 32'h0706_0504);

      // 6: asynchronous reset mid-frame with output pending
      err_count = 0;
      out_ready = 1'b0;
      send(1'b1, 8'h91);
      send(1'b0, 8'h92);
      send(1'b0, 8'h93);
      send(1'b0, 8'h94);
      send(1'b1, 8'h81);
      send(1'b0, 8'h82);
      check("t6_pending", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      check("t6_async_valid", 64'(out_valid), 64'(0));
      check("t6_async_data",  64'(out_data),  64'(0));
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(1);
      send(1'b1, 8'hDE);
      send(1'b0, 8'hAD);
      send(1'b0, 8'hBE);
      send(1'b0, 8'hEF);
      check("t6_valid", 64'(out_valid), 64'(1));
      check("t6_data",  64'(out_data),  64'hEFBE_ADDE);
      idle(2);
      check_frames("t6_frame", 32'hEFBE_ADDE);
      check("t6_no_err", 64'(err_count), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
